// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single synchronous RAM port between the CPU and the front panel.
// The CPU may only touch memory while it is running. The panel writes in IN
// mode and reads in CHECK and RUN modes. When both want the RAM, the CPU has
// priority. A saturating starvation counter guarantees the panel a slot after
// STARVE_MAX consecutive CPU wins.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cpustate[1:0]            00 IN, 01 CHECK, 11 RUN, 10 reserved
//   cpu_read, cpu_write      CPU requests, held until granted
//   cpu_addr, cpu_wdata      CPU address / write data
//   cpu_wait                 CPU request pending but not granted this cycle
//   cpu_rvalid, cpu_rdata    CPU read response, one cycle after the grant
//   pnl_req, pnl_ack         panel four-phase handshake
//   pnl_ld, pnl_addr         load strobe / value for the panel address counter
//   pnl_wdata                panel write data
//   pnl_rdata                last panel read data
//   pnl_cur_addr             panel address counter
//   mem_en, mem_we           RAM enable / write enable
//   mem_addr, mem_wdata      RAM address / write data
//   mem_rdata                RAM read data, valid one cycle after a read
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cpustate,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_wait,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    input  logic        pnl_req,
    input  logic        pnl_ld,
    input  logic [15:0] pnl_addr,
    input  logic [7:0]  pnl_wdata,
    output logic        pnl_ack,
    output logic [7:0]  pnl_rdata,
    output logic [15:0] pnl_cur_addr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic {
        IDLE     = 1'b0,
        PNL_RESP = 1'b1
    } state_t;

    localparam logic [1:0] MODE_IN       = 2'b00;
    localparam logic [1:0] MODE_RESERVED = 2'b10;
    localparam logic [1:0] MODE_RUN      = 2'b11;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // Saturating increment of the starvation counter.
    function automatic logic [3:0] starve_inc(input logic [3:0] v);
        if (v >= STARVE_LIM) begin
            return STARVE_LIM;
        end
        return v + 4'd1;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic        pnl_ack_q, pnl_ack_d;
    logic        pnl_rd_q, pnl_rd_d;

    logic        cpu_req;
    logic        cpu_elig;
    logic        pnl_elig;
    logic        pnl_is_write;
    logic        pnl_win;
    logic        cpu_win;

    // Arbitration. Grants are suppressed while reset is held so the RAM is
    // never enabled during reset, but cpu_wait still shows a pending request.
    always_comb begin
        cpu_req      = cpu_read | cpu_write;
        cpu_elig     = !rst && (cpustate == MODE_RUN) && cpu_req;
        pnl_elig     = !rst && (cpustate != MODE_RESERVED) &&
                       (state_q == IDLE) && pnl_req;
        pnl_is_write = (cpustate == MODE_IN);
        pnl_win      = pnl_elig && (!cpu_elig || (starve_q == STARVE_LIM));
        cpu_win      = cpu_elig && !pnl_win;
    end

    // RAM port mux and CPU wait.
    always_comb begin
        mem_en    = pnl_win | cpu_win;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (pnl_win) begin
            mem_we    = pnl_is_write;
            mem_addr  = addr_q;
            mem_wdata = pnl_wdata;
        end else if (cpu_win) begin
            // Read and write together is performed as a write.
            mem_we = cpu_write;
        end
        cpu_wait = cpu_req && !cpu_win;
    end

    // Next-state logic for the FSM, starvation counter and response flags.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        cpu_rvalid_d = cpu_win && !cpu_write;
        pnl_ack_d    = pnl_win;
        pnl_rd_d     = pnl_win && !pnl_is_write;

        case (state_q)
            IDLE: begin
                if (pnl_win) begin
                    state_d = PNL_RESP;
                end
            end
            PNL_RESP: begin
                if (!pnl_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter only advances when the panel lost purely on priority.
        if (pnl_win || !pnl_req) begin
            starve_d = 4'd0;
        end else if (cpu_win && pnl_elig) begin
            starve_d = starve_inc(starve_q);
        end

        // A load strobe overrides the post-access increment.
        if (pnl_ld) begin
            addr_d = pnl_addr;
        end else if (pnl_win) begin
            addr_d = addr_q + 16'd1;
        end

        // RAM data for a panel read arrives the cycle after the grant.
        if (pnl_rd_q) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_q     <= 4'd0;
            addr_q       <= 16'h0000;
            rdata_q      <= 8'h00;
            cpu_rvalid_q <= 1'b0;
            pnl_ack_q    <= 1'b0;
            pnl_rd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            pnl_ack_q    <= pnl_ack_d;
            pnl_rd_q     <= pnl_rd_d;
        end
    end

    assign cpu_rvalid   = cpu_rvalid_q;
    assign cpu_rdata    = mem_rdata;
    assign pnl_ack      = pnl_ack_q;
    assign pnl_rdata    = rdata_q;
    assign pnl_cur_addr = addr_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 8: consecutive CPU-won cycles after which a pending panel request SHALL win.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 cpustate  input  2  CPU mode, encoded as follows: 00 IN, 01 CHECK, 11 RUN, 10 reserved.
REQ-005 cpu_read  input  1  CPU read request; held high until granted.
REQ-006 cpu_write  input  1  CPU write request; held high until granted.
REQ-007 cpu_addr  input  16  CPU address; stable while a request is high.
REQ-008 cpu_wdata  input  8  CPU write data.
REQ-009 cpu_wait  output  1  high while a CPU request is pending and not granted this cycle.
REQ-010 cpu_rvalid  output  1  high in the cycle after a granted CPU read.
REQ-011 cpu_rdata  output  8  equals mem_rdata while cpu_rvalid is high.
REQ-012 pnl_req  input  1  front-panel request; four-phase handshake with pnl_ack.
REQ-013 pnl_ld  input  1  one-cycle strobe that loads the panel address counter.
REQ-014 pnl_addr  input  16  load value for the panel address counter.
REQ-015 pnl_wdata  input  8  panel write data.
REQ-016 pnl_ack  output  1  one-cycle acknowledge of a panel access.
REQ-017 pnl_rdata  output  8  last panel read data; held until the next panel read.
REQ-018 pnl_cur_addr  output  16  panel address counter.
REQ-019 mem_en, mem_we  output  1 each  RAM enable and write enable.
REQ-020 mem_addr  output  16  and  mem_wdata  output  8  RAM address and write data.
REQ-021 mem_rdata  input  8  synchronous RAM read data, valid one cycle after a read enable.

Function
REQ-022 FSM states: IDLE and PNL_RESP (panel acknowledged, waiting for pnl_req low); STARVE is a 4-bit saturating counter.
REQ-023 Eligibility:
- CPU is eligible only when cpustate==11.
- Panel is eligible in IN (write access), CHECK (read access) and RUN (read access).
- In the reserved state 10, neither requester is eligible.
- Panel is eligible only in IDLE with pnl_req high.
REQ-024 Arbitration, evaluated combinationally each cycle:
- Panel wins if eligible and (no eligible CPU request, or STARVE==STARVE_MAX).
- Otherwise an eligible CPU request wins.
- At most one grant per cycle.
REQ-025 Grant cycle N:
- mem_en=1; mem_addr, mem_we and mem_wdata are taken from the winner.
- A losing or ineligible CPU request forces cpu_wait=1.
- mem_en=0 when there is no grant.
REQ-026 CPU read granted in N: cpu_rvalid=1 in N+1 with cpu_rdata=mem_rdata; a CPU write produces no response.
REQ-027 cpu_read and cpu_write both high: performed as a write.
REQ-028 Panel grant in N:
- pnl_ack=1 in N+1.
- Reads latch mem_rdata into pnl_rdata at the end of N+1.
- pnl_cur_addr increments at the N→N+1 edge, wrapping FFFF→0000.
- FSM moves to PNL_RESP.
REQ-029 PNL_RESP returns to IDLE the cycle after pnl_req is sampled low; CPU grants continue during PNL_RESP.
REQ-030 STARVE behaviour:
- Increments on each CPU grant while pnl_req is high and the panel is eligible-but-for-priority.
- Clears on a panel grant or when pnl_req is low.
- Saturates at STARVE_MAX.
REQ-031 pnl_ld loads pnl_cur_addr from pnl_addr; a load coincident with an increment SHALL take the loaded value.
REQ-032 cpustate change mid-operation: an outstanding read response (cpu_rvalid/pnl_ack) SHALL still complete in the next cycle; new grants follow the new mode.

Reset
REQ-033 While rst is high:
- FSM=IDLE, STARVE=0, pnl_cur_addr=0000, pnl_rdata=00.
- cpu_rvalid, pnl_ack, mem_en and mem_we =0.
- cpu_wait reflects any pending request.
REQ-034 A reset asserted mid-access SHALL cancel the pending response; no ack or rvalid is produced after rst deasserts.

Verification
REQ-035 IN mode, pnl_ld with 0x0010, then three pnl_req/wdata (AA, BB, CC) handshakes -> writes land at 0010/0011/0012, three pnl_ack pulses, pnl_cur_addr=0013.
REQ-036 RUN mode, cpu_read at 0x0040 with the RAM holding 5A -> mem_en in N, cpu_rvalid=1 and cpu_rdata=5A in N+1, cpu_wait=0.
REQ-037 RUN mode, cpu_read held continuously plus pnl_req -> eight CPU grants, then one panel read with cpu_wait=1 for that cycle, then CPU grants resume.
REQ-038 CHECK mode, cpu_write held -> cpu_wait stays 1, no mem_we; switching to RUN -> write is performed the same cycle.
REQ-039 pnl_cur_addr=FFFF, panel write -> pnl_cur_addr=0000; pnl_ld coincident with a grant -> loaded value wins.
REQ-040 rst asserted in the cycle after a panel read grant -> no pnl_ack, pnl_rdata=00, FSM=IDLE.
